// File: rtl/pilha_pkg.sv
// Shared defaults for the return-address stack and the PC-mux select that picks it.
package pilha_pkg;

  localparam int unsigned PILHA_DEPTH = 16;
  localparam int unsigned PILHA_WIDTH = 32;

  // PC mux input fed by the top of the return-address stack.
  localparam logic [1:0] SEL_PC_PILHA = 2'b11;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_CLEAR,
    OP_PUSHPOP,
    OP_PUSH,
    OP_POP
  } pilha_op_e;

endpackage

// File: rtl/pilha_retorno_if.sv
// Strobe/data bundle between the control unit and the return-address stack.
interface pilha_retorno_if #(
  parameter int unsigned DEPTH = pilha_pkg::PILHA_DEPTH,
  parameter int unsigned WIDTH = pilha_pkg::PILHA_WIDTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
);
  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, clear, data_in,
    input  data_out, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, clear, data_in,
    output data_out, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/pilha_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module pilha_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pilha_retorno.sv
// Hardware return-address stack: jal pushes the return PC, jst pops it to the PC mux.
module pilha_retorno
  import pilha_pkg::*;
#(
  parameter int unsigned DEPTH = PILHA_DEPTH,
  parameter int unsigned WIDTH = PILHA_WIDTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  pilha_retorno_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  pilha_op_e        op;
  logic [PTR_W:0]   sp_q, sp_d;
  logic [PTR_W:0]   top_idx;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty, full;
  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [WIDTH-1:0] rdata;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == FULL_CNT);
  assign top_idx = sp_q - 1'b1;

  always_comb begin
    op = OP_IDLE;
    if (bus.clear)                 op = OP_CLEAR;
    else if (bus.push && bus.pop)  op = OP_PUSHPOP;
    else if (bus.push)             op = OP_PUSH;
    else if (bus.pop)              op = OP_POP;
  end

  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = sp_q[PTR_W-1:0];
    case (op)
      OP_CLEAR: begin
        sp_d  = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      OP_PUSHPOP: begin
        // Empty stack degrades to a plain push; otherwise the top is replaced in place.
        if (empty) begin
          we   = 1'b1;
          sp_d = sp_q + 1'b1;
        end else begin
          we    = 1'b1;
          waddr = top_idx[PTR_W-1:0];
        end
      end
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + 1'b1;
        end
      end
      OP_POP: begin
        if (empty) unf_d = 1'b1;
        else       sp_d  = sp_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // The array has no reset, so a write must be blocked while reset is held.
  pilha_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we && reset),
    .waddr_i (waddr),
    .wdata_i (bus.data_in),
    .raddr_i (top_idx[PTR_W-1:0]),
    .rdata_o (rdata)
  );

  assign bus.data_out  = empty ? '0 : rdata;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = sp_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_pilha_retorno.sv
// Directed plus random bench for pilha_retorno against a queue-based LIFO model.
module tb_pilha_retorno;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 32;

  logic clk;
  logic reset;

  pilha_retorno_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  pilha_retorno #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model_q [$];
  logic        m_ovf;
  logic        m_unf;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [31:0] exp_top;
    exp_top = (model_q.size() == 0) ? 32'h0 : model_q[$];
    chk({where, ".count"},     32'(bus.count),     32'(model_q.size()));
    chk({where, ".empty"},     32'(bus.empty),     32'(model_q.size() == 0));
    chk({where, ".full"},      32'(bus.full),      32'(model_q.size() == DEPTH));
    chk({where, ".data_out"},  bus.data_out,       exp_top);
    chk({where, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    chk({where, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
  endtask

  task automatic model_step(input logic p, input logic po, input logic c, input logic [31:0] d);
    if (c) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && po) begin
      if (model_q.size() == 0) model_q.push_back(d);
      else                     model_q[model_q.size()-1] = d;
    end else if (p) begin
      if (model_q.size() == DEPTH) m_ovf = 1'b1;
      else                         model_q.push_back(d);
    end else if (po) begin
      if (model_q.size() == 0) m_unf = 1'b1;
      else                     void'(model_q.pop_back());
    end
  endtask

  // Drive on the falling edge, check pre-edge outputs, then let the rising edge act.
  task automatic cycle(input string where, input logic p, input logic po,
                       input logic c, input logic [31:0] d);
    @(negedge clk);
    bus.push    = p;
    bus.pop     = po;
    bus.clear   = c;
    bus.data_in = d;
    #1;
    check_all(where);
    @(posedge clk);
    model_step(p, po, c, d);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    reset   = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.clear = 1'b0;
    bus.data_in = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    cycle("reset_idle", 1'b0, 1'b0, 1'b0, 32'h0);

    cycle("push10", 1'b1, 1'b0, 1'b0, 32'h10);
    cycle("push20", 1'b1, 1'b0, 1'b0, 32'h20);
    cycle("push30", 1'b1, 1'b0, 1'b0, 32'h30);
    cycle("pop30",  1'b0, 1'b1, 1'b0, 32'h0);
    cycle("pop20",  1'b0, 1'b1, 1'b0, 32'h0);
    cycle("pop10",  1'b0, 1'b1, 1'b0, 32'h0);
    cycle("after_pops", 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < int'(DEPTH); i++)
      cycle("fill", 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
    cycle("push_full", 1'b1, 1'b0, 1'b0, 32'hDEAD);
    cycle("full_idle", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("full_top_10f", bus.data_out, 32'h10F);
    for (int i = 0; i < int'(DEPTH); i++)
      cycle("drain", 1'b0, 1'b1, 1'b0, 32'h0);

    cycle("pop_empty", 1'b0, 1'b1, 1'b0, 32'h0);
    cycle("clear",     1'b0, 1'b0, 1'b1, 32'h0);
    cycle("push44",    1'b1, 1'b0, 1'b0, 32'h44);
    cycle("see44",     1'b0, 1'b0, 1'b0, 32'h0);
    chk("top_44", bus.data_out, 32'h44);
    cycle("clear2",    1'b0, 1'b0, 1'b1, 32'h0);

    cycle("push55",    1'b1, 1'b0, 1'b0, 32'h55);
    cycle("repl66",    1'b1, 1'b1, 1'b0, 32'h66);
    cycle("see66",     1'b0, 1'b0, 1'b0, 32'h0);
    chk("top_66", bus.data_out, 32'h66);
    cycle("pop66",     1'b0, 1'b1, 1'b0, 32'h0);
    cycle("pp_empty77", 1'b1, 1'b1, 1'b0, 32'h77);
    cycle("see77",     1'b0, 1'b0, 1'b0, 32'h0);
    chk("top_77", bus.data_out, 32'h77);
    chk("unf_77", 32'(bus.underflow), 32'h0);

    cycle("pushAA", 1'b1, 1'b0, 1'b0, 32'hAA);
    cycle("pushBB", 1'b1, 1'b0, 1'b0, 32'hBB);
    // Reset dropped between edges while a push is pending through the next edge.
    @(negedge clk);
    bus.push    = 1'b1;
    bus.pop     = 1'b0;
    bus.clear   = 1'b0;
    bus.data_in = 32'hEE;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("rst_count",    32'(bus.count), 32'h0);
    chk("rst_data_out", bus.data_out,   32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.push = 1'b0;
    #1;
    check_all("in_reset");
    reset = 1'b1;
    cycle("pushCC", 1'b1, 1'b0, 1'b0, 32'hCC);
    cycle("seeCC",  1'b0, 1'b0, 1'b0, 32'h0);
    chk("top_CC",   bus.data_out,   32'hCC);
    chk("count_CC", 32'(bus.count), 32'h1);

    for (int i = 0; i < 400; i++) begin
      logic c, p, po;
      c  = ($urandom_range(0, 99) < 3);
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      cycle("rand", p, po, c, $urandom);
    end
    cycle("final", 1'b0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pilha_retorno.md
Name: pilha_retorno

Overview:
- Hardware return-address stack (LIFO) that consumes the push/pop strobes issued by the multicycle control unit.
- jal pushes the return address (PC of the instruction after jal).
- jst pops it, and top-of-stack is fed to the PC mux input 2'b11.
- Sits beside the PC register in the datapath, clocked on posedge clk like the state register.

Parameters:
DEPTH, 16, number of stack entries (power of two, >= 2)
WIDTH, 32, return-address width in bits (matches PC width)
PTR_W, $clog2(DEPTH), stack-pointer/index width

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
push  input  1  push strobe from control unit (jal, ESTADO13)
pop  input  1  pop strobe from control unit (jst, ESTADO10)
clear  input  1  synchronous flush of all entries; error flags are cleared
data_in  input  WIDTH  return address to push
data_out  output  WIDTH  current top-of-stack entry; 0 when empty
empty  output  1  stack holds 0 entries
full  output  1  stack holds DEPTH entries
count  output  PTR_W+1  number of valid entries
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset=0, asynchronous):
  - sp=0, count=0, empty=1, full=0, overflow=0, underflow=0, data_out=0.
  - Array contents are don't-care and need not be reset.
- Operation is level-sampled: every posedge with the strobe high performs one operation. The control unit guarantees single-cycle strobes.
- Priority at each posedge: clear > (push&pop) > push > pop > idle.
- clear=1: sp=0; overflow=0; underflow=0; push and pop are ignored that cycle.
- push only:
  - If not full: mem[sp] <= data_in, sp <= sp+1.
  - If full: no write, sp unchanged, overflow <= 1.
- pop only:
  - If not empty: sp <= sp-1.
  - If empty: sp unchanged, underflow <= 1.
- push & pop in the same cycle:
  - If not empty: mem[sp-1] <= data_in (replace top), sp unchanged.
  - If empty: behaves as push; no underflow is flagged.
- Read timing:
  - data_out is a combinational read of mem[sp-1], forced to 0 when empty.
  - The value is valid throughout the cycle in which pop is high. The PC therefore captures the pre-pop top at the same posedge the pop takes effect (jst: EscrevePC, SelMuxPC=11 and pop asserted together).
  - After a push, data_out shows the new entry from the following cycle.
- Flags: empty = (count==0) and full = (count==DEPTH), both derived combinationally from sp.
- Sticky flags remain set until clear or reset. Ignored operations never corrupt sp or the array.
- No wrap-around: sp saturates at 0 and DEPTH through the guards above, and pointer arithmetic is PTR_W+1 bits wide.
- Reset asserted mid-operation aborts any pending write. After reset deasserts, the first posedge behaves as from an empty stack.

Decomposition:
- Shared package (pilha_pkg): WIDTH/DEPTH defaults and the PC-mux select constant for the stack source (2'b11).
- One sub-module, pilha_mem: a DEPTH x WIDTH register array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata), with no reset.
- Pointer logic and flags stay in pilha_retorno.

Test Plan:
- Reset then idle -> empty=1, count=0, data_out=0, overflow=0, underflow=0.
- Push 0x10, 0x20, 0x30 on consecutive cycles, then pop three times:
  - data_out reads 0x30, 0x20, 0x10 in the respective pop cycles.
  - After the last pop: empty=1, data_out=0.
- Push DEPTH entries (0x100+i), then one more push of 0xDEAD:
  - full=1, overflow=1, count=DEPTH, data_out=0x10F (DEPTH=16).
  - 0xDEAD is never observed on later pops.
- Pop while empty -> underflow=1, count stays 0.
  - Then clear=1 for one cycle -> underflow=0.
  - Then push 0x44 -> data_out=0x44.
- Push 0x55, then push=pop=1 with data_in 0x66 -> count=1, data_out=0x66.
  - Repeating push=pop=1 on the empty stack with 0x77 -> count=1, data_out=0x77, underflow=0.
- Push 0xAA and 0xBB, then drop reset low between posedges -> count=0 and data_out=0 immediately.
  - After release, push 0xCC -> data_out=0xCC, count=1.
